// File: rtl/ika2151_so_deserializer_if.sv
// Serial link between the IKA2151 core's DAC outputs and the deserializer, plus the parallel PCM results.
// The o_FRAME_ERR signal exists only when IKA2151_DESER_FRAMECHK_EN is defined.
interface ika2151_so_deserializer_if;
    logic        i_phi1_PCEN_n;
    logic        i_SO;
    logic        i_SH1;
    logic        i_SH2;
    logic [15:0] o_L;
    logic [15:0] o_R;
    logic        o_L_VALID;
    logic        o_R_VALID;
`ifdef IKA2151_DESER_FRAMECHK_EN
    logic        o_FRAME_ERR;

    modport master (output i_phi1_PCEN_n, i_SO, i_SH1, i_SH2,
                    input  o_L, o_R, o_L_VALID, o_R_VALID, o_FRAME_ERR);
    modport slave  (input  i_phi1_PCEN_n, i_SO, i_SH1, i_SH2,
                    output o_L, o_R, o_L_VALID, o_R_VALID, o_FRAME_ERR);
`else
    modport master (output i_phi1_PCEN_n, i_SO, i_SH1, i_SH2,
                    input  o_L, o_R, o_L_VALID, o_R_VALID);
    modport slave  (input  i_phi1_PCEN_n, i_SO, i_SH1, i_SH2,
                    output o_L, o_R, o_L_VALID, o_R_VALID);
`endif
endinterface

// File: rtl/ika2151_so_deserializer.sv
// YM2151 floating-point DAC stream (SO/SH1/SH2) to two 16-bit signed PCM samples.
// Optional word-length checking with sticky error: define IKA2151_DESER_FRAMECHK_EN.
module ika2151_so_deserializer (
    input  logic                          i_EMUCLK,
    input  logic                          i_MRST_n,
    ika2151_so_deserializer_if.slave      bus
);
    logic [12:0]        r_sr;
    logic               r_sh1_d;
    logic               r_sh2_d;
    logic signed [15:0] r_l_p1;
    logic signed [15:0] r_r_p1;
    logic               r_l_vld_p1;
    logic               r_r_vld_p1;

    logic               w_strobe;
    logic               w_fall1;
    logic               w_fall2;
    logic               w_accept;
    logic [12:0]        w_word;
    logic signed [15:0] w_out;

    // Offset-binary mantissa to signed, then scale by the exponent; e == 0 means silence.
    function automatic logic signed [15:0] fp_to_pcm(input logic [12:0] w);
        logic signed [15:0] s16;
        logic [2:0]         e;
        s16 = {{6{~w[9]}}, ~w[9], w[8:0]};
        e   = w[12:10];
        if (e == 3'd0)
            return '0;
        return s16 <<< (e - 3'd1);
    endfunction

    assign w_strobe = ~bus.i_phi1_PCEN_n;
    assign w_word   = {bus.i_SO, r_sr[12:1]};
    assign w_fall1  = r_sh1_d & ~bus.i_SH1;
    assign w_fall2  = r_sh2_d & ~bus.i_SH2;
    assign w_out    = fp_to_pcm(w_word);

`ifdef IKA2151_DESER_FRAMECHK_EN
    logic [4:0] r_cnt;
    logic       r_frame_err;

    // cnt == 15 on the closing strobe means exactly 16 strobes since the previous close.
    assign w_accept        = (r_cnt == 5'd15);
    assign bus.o_FRAME_ERR = r_frame_err;
`else
    assign w_accept = 1'b1;
`endif

    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            r_sr       <= '0;
            r_sh1_d    <= 1'b0;
            r_sh2_d    <= 1'b0;
            r_l_p1     <= '0;
            r_r_p1     <= '0;
            r_l_vld_p1 <= 1'b0;
            r_r_vld_p1 <= 1'b0;
`ifdef IKA2151_DESER_FRAMECHK_EN
            r_cnt       <= 5'd31;
            r_frame_err <= 1'b0;
`endif
        end else begin
            r_l_vld_p1 <= 1'b0;
            r_r_vld_p1 <= 1'b0;
            if (w_strobe) begin
                r_sr    <= w_word;
                r_sh1_d <= bus.i_SH1;
                r_sh2_d <= bus.i_SH2;
                if (w_fall1 && w_accept) begin
                    r_l_p1     <= w_out;
                    r_l_vld_p1 <= 1'b1;
                end
                if (w_fall2 && w_accept) begin
                    r_r_p1     <= w_out;
                    r_r_vld_p1 <= 1'b1;
                end
`ifdef IKA2151_DESER_FRAMECHK_EN
                if (w_fall1 || w_fall2) begin
                    r_cnt <= 5'd0;
                    if (!w_accept)
                        r_frame_err <= 1'b1;
                end else if (r_cnt != 5'd31) begin
                    r_cnt <= r_cnt + 5'd1;
                end
`endif
            end
        end
    end

    // Output stage: registered on the closing strobe, one EMUCLK after it.
    assign bus.o_L       = r_l_p1;
    assign bus.o_R       = r_r_p1;
    assign bus.o_L_VALID = r_l_vld_p1;
    assign bus.o_R_VALID = r_r_vld_p1;
endmodule

// File: tb/tb_ika2151_so_deserializer.sv
// Randomized scoreboard bench for ika2151_so_deserializer; follows IKA2151_DESER_FRAMECHK_EN if defined.
module tb_ika2151_so_deserializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ika2151_so_deserializer_if bus ();

    ika2151_so_deserializer dut (
        .i_EMUCLK (clk),
        .i_MRST_n (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: last 13 serial bits, previous SH levels, expected-output queues.
    logic        hist[$];
    logic        prev1, prev2;
    logic [15:0] qL[$];
    logic [15:0] qR[$];
    logic [15:0] mdl_L, mdl_R;
`ifdef IKA2151_DESER_FRAMECHK_EN
    int          since;
    logic        mdl_err;
`endif

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (13) hist.push_back(1'b0);
        prev1 = 1'b0;
        prev2 = 1'b0;
        mdl_L = 16'h0;
        mdl_R = 16'h0;
`ifdef IKA2151_DESER_FRAMECHK_EN
        since   = 99;
        mdl_err = 1'b0;
`endif
    endtask

    // Spec-level conversion: value = (m - 512) * 2^(e-1), zero when e == 0.
    function automatic logic [15:0] expect_word();
        int m, e, v;
        m = 0;
        e = 0;
        for (int k = 0; k < 10; k++) m += int'(hist[k]) << k;
        for (int k = 0; k < 3; k++)  e += int'(hist[10 + k]) << k;
        v = (e == 0) ? 0 : (m - 512) * (1 << (e - 1));
        return v[15:0];
    endfunction

    task automatic strobe(input logic so, input logic sh1, input logic sh2);
        logic f1, f2, ok;
        logic [15:0] x;
        @(negedge clk);
        bus.i_SO          = so;
        bus.i_SH1         = sh1;
        bus.i_SH2         = sh2;
        bus.i_phi1_PCEN_n = 1'b0;
        hist.push_back(so);
        if (hist.size() > 13) void'(hist.pop_front());
        f1 = prev1 & ~sh1;
        f2 = prev2 & ~sh2;
        prev1 = sh1;
        prev2 = sh2;
`ifdef IKA2151_DESER_FRAMECHK_EN
        if (since < 99) since++;
        ok = (since == 16);
        if (f1 | f2) begin
            since = 0;
            if (!ok) mdl_err = 1'b1;
        end
`else
        ok = 1'b1;
`endif
        if ((f1 | f2) && ok) begin
            x = expect_word();
            if (f1) begin qL.push_back(x); mdl_L = x; end
            if (f2) begin qR.push_back(x); mdl_R = x; end
        end
        @(posedge clk);
        #1 bus.i_phi1_PCEN_n = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame of len strobes; the last 13 bits carry m (LSB first) then e; SH of chosen channels falls on the last.
    task automatic send_word(input logic c1, input logic c2, input int m, input int e,
                             input int len, input bit jitter);
        logic [9:0] mv;
        logic [2:0] ev;
        logic       b;
        int         j;
        mv = m[9:0];
        ev = e[2:0];
        for (int i = 0; i < len; i++) begin
            j = i - (len - 13);
            if (j < 0)       b = 1'($urandom_range(0, 1));
            else if (j < 10) b = mv[j];
            else             b = ev[j - 10];
            strobe(b, c1 && (i != len - 1), c2 && (i != len - 1));
            if (jitter) gap($urandom_range(0, 2));
        end
        gap(2);
        chk("L_hold", bus.o_L, mdl_L);
        chk("R_hold", bus.o_R, mdl_R);
    endtask

    task automatic check_err();
`ifdef IKA2151_DESER_FRAMECHK_EN
        chk("frame_err", {15'h0, bus.o_FRAME_ERR}, {15'h0, mdl_err});
`endif
    endtask

    task automatic check_reset_state();
        chk("rst_L", bus.o_L, 16'h0);
        chk("rst_R", bus.o_R, 16'h0);
        chk("rst_L_VALID", {15'h0, bus.o_L_VALID}, 16'h0);
        chk("rst_R_VALID", {15'h0, bus.o_R_VALID}, 16'h0);
        check_err();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        check_reset_state();
    endtask

    // Monitor: every VALID pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.o_L_VALID) begin
            if (qL.size() == 0) begin
                checks++; errors++;
                $display("FAIL L_unexpected: got valid %h expected no pulse", bus.o_L);
            end else chk("L_word", bus.o_L, qL.pop_front());
        end
        if (bus.o_R_VALID) begin
            if (qR.size() == 0) begin
                checks++; errors++;
                $display("FAIL R_unexpected: got valid %h expected no pulse", bus.o_R);
            end else chk("R_word", bus.o_R, qR.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        int ch, len;
        bus.i_phi1_PCEN_n = 1'b1;
        bus.i_SO  = 1'b0;
        bus.i_SH1 = 1'b0;
        bus.i_SH2 = 1'b0;
        model_reset();
        gap(3);
        check_reset_state();
        #1 rst_n = 1'b1;

        // Priming word: in frame-check builds the first close after reset is rejected.
        send_word(1, 0, 'h3FF, 7, 16, 0);
        check_err();
        send_word(1, 0, 'h3FF, 7, 16, 0);
        send_word(0, 1, 'h000, 7, 16, 1);
        send_word(1, 0, 'h201, 1, 16, 0);
        send_word(0, 1, 'h1FF, 3, 16, 1);
        send_word(1, 0, 'h155, 0, 16, 0);
        send_word(1, 1, 'h300, 2, 16, 0);

        // Short frame then a correct one.
        send_word(1, 0, 'h123, 5, 15, 0);
        check_err();
        send_word(0, 1, 'h2AA, 4, 16, 1);
        check_err();

        // Reset in the middle of a word, then SH low on the first strobe afterwards.
        for (int i = 0; i < 7; i++) strobe(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        do_reset();
        strobe(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk("post_rst_L_VALID", {15'h0, bus.o_L_VALID}, 16'h0);
        chk("post_rst_R_VALID", {15'h0, bus.o_R_VALID}, 16'h0);
        check_reset_state();

        for (int n = 0; n < 40; n++) begin
            ch  = $urandom_range(0, 2);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(14, 18) : 16;
            send_word(ch != 1, ch != 0, $urandom_range(0, 1023), $urandom_range(0, 7),
                      len, 1'($urandom_range(0, 1)));
            check_err();
        end

        gap(4);
        chk("L_queue_empty", 16'(qL.size()), 16'h0);
        chk("R_queue_empty", 16'(qR.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ika2151_so_deserializer.md
# ika2151_so_deserializer

Deserializes the YM2151 floating-point DAC serial stream (SO, SH1, SH2) into two parallel 16-bit signed PCM samples. It sits directly downstream of the IKA2151 core and replaces the external YM3012 DAC in FPGA builds. It runs on the emulator master clock and samples its serial inputs only on the core's phi1 positive clock-enable strobe.

## Interface
Parameters
- None.

Ports
- i_EMUCLK  in  1  emulator master clock; sole clock.
- i_MRST_n  in  1  synchronous, active-low reset.
- i_phi1_PCEN_n  in  1  phi1 positive-edge enable; low = sample strobe.
- i_SO  in  1  serial data from core, LSB first.
- i_SH1  in  1  channel-1 sample/hold; falling edge closes a channel-1 word.
- i_SH2  in  1  channel-2 sample/hold; falling edge closes a channel-2 word.
- o_L  out  16  channel-1 sample, two's complement.
- o_R  out  16  channel-2 sample, two's complement.
- o_L_VALID  out  1  one-EMUCLK pulse when o_L updates.
- o_R_VALID  out  1  one-EMUCLK pulse when o_R updates.
- o_FRAME_ERR  out  1  sticky framing error; present only with IKA2151_DESER_FRAMECHK_EN.

## Operation
- Strobe = i_EMUCLK rising edge with i_phi1_PCEN_n == 0. All state other than the valid pulses changes only on strobes.
- Shift register sr[12:0]. On each strobe: sr <= {i_SO, sr[12:1]}.
- Edge detect: sh1_d/sh2_d hold the SH values sampled on the previous strobe. A fall is sh_d == 1 and current SH == 0, evaluated on the same strobe.
- Word decode uses the post-shift value, so the SO bit sampled on the edge strobe is included: w = {i_SO, sr[12:1]}. Mantissa m = w[9:0], exponent e = w[12:10].
- Word framing: 16 bits per channel. The first 3 bits are ignored, followed by 10 mantissa bits and 3 exponent bits.
- Conversion:
  - s = m - 512, a 10-bit signed value (offset binary; m[9] = 1 means non-negative).
  - For e in 1..7: out = sign-extend(s) << (e-1), producing 16 bits.
  - For e == 0: out = 0.
- SH1 fall: o_L <= out and o_L_VALID pulses. SH2 fall: o_R <= out and o_R_VALID pulses.
- If SH1 and SH2 fall on the same strobe, both channels latch the same word and both valid pulses fire.
- Reset:
  - sr = 0, sh1_d = sh2_d = 0. This prevents a spurious fall on the first strobe after reset.
  - o_L = o_R = 0, both VALID = 0, o_FRAME_ERR = 0, bit counter = 31.
- Reset asserted mid-word discards the partial word. The next edge after reset is treated per the Configuration section.

## Timing
- Latency: o_L/o_R and the VALID pulse appear on the first i_EMUCLK edge after the edge strobe. Implement as one register stage: decode is combinational from w, and outputs are registered on the strobe.
- VALID is high for exactly one i_EMUCLK cycle, regardless of how long i_phi1_PCEN_n stays low.
- o_L/o_R hold their value between updates.
- No backpressure; the consumer must accept each pulse.

## Configuration
- Macro: IKA2151_DESER_FRAMECHK_EN.
- Defined:
  - A 5-bit counter cnt counts strobes since the last SH-fall strobe. On a non-edge strobe it increments, saturating at 31. On an edge strobe it resets to 0.
  - At an edge strobe, if cnt != 15 (the word is not exactly 16 strobes long): o_FRAME_ERR sets, and the channel output and its VALID are suppressed.
  - o_FRAME_ERR clears only on reset.
  - The first edge after reset is always rejected (cnt = 31).
- Undefined:
  - No counter and no o_FRAME_ERR port.
  - Every SH fall latches, whatever the word length.

## Test plan
- Word m=0x3FF, e=7, then SH1 fall -> o_L = 0x7FC0 and one o_L_VALID pulse.
- Word m=0x000, e=7, then SH2 fall -> o_R = 0x8000; o_L unchanged.
- Word m=0x201, e=1 -> out = 0x0001. Word m=0x1FF, e=3 -> out = 0xFFFC. Word m=0x155, e=0 -> out = 0x0000.
- SH1 and SH2 falling on the same strobe with m=0x300, e=2 -> o_L = o_R = 0x0200, both VALID pulse in the same cycle.
- FRAMECHK_EN, edge spacing 15 strobes -> o_FRAME_ERR = 1, no VALID, outputs unchanged. Next spacing 16 -> latches; o_FRAME_ERR stays 1 until reset.
- Assert i_MRST_n low for 1 cycle mid-word -> all outputs 0, no VALID on the first post-reset strobe even with SH low.
